// File: rtl/bqf_stim_gen_if.sv
// Sample stream from the stimulus generator into the biquad Xin port.
interface bqf_stim_gen_if #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) ();
    logic [W-1:0]     x_out;
    logic             x_valid;
    logic             x_ready;
    logic [CNT_W-1:0] idx;

    modport master (output x_out, output x_valid, output idx, input x_ready);
    modport slave  (input x_out, input x_valid, input idx, output x_ready);
endinterface

// File: rtl/bqf_stim_gen.sv
// Length-limited test-stimulus source (impulse/step/ramp/noise) for the biquad Xin input.
module bqf_stim_gen #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [W-1:0]     amp,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    output logic             done,
    bqf_stim_gen_if.master   xs
);

    localparam logic [31:0] NOISE_TAPS = 32'h8020_0003;

    typedef enum logic {S_IDLE, S_RUN} state_t;
    typedef enum logic [1:0] {M_IMPULSE, M_STEP, M_RAMP, M_NOISE} mode_t;

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [W-1:0]     amp_q, amp_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [W-1:0]     x_out_q, x_out_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic             done_q, done_d;

    logic [31:0]      seed_c;
    logic [31:0]      lfsr_nxt_c;

    // One step of the Galois noise register.
    function automatic logic [31:0] lfsr_next(input logic [31:0] q);
        return (q >> 1) ^ (q[0] ? NOISE_TAPS : 32'h0);
    endfunction

    // A zero seed would lock the noise register, so it is replaced by 1.
    assign seed_c     = (amp == '0) ? 32'd1 : 32'(amp);
    assign lfsr_nxt_c = lfsr_next(lfsr_q);

    // State and datapath registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            mode_q  <= M_IMPULSE;
            amp_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            x_out_q <= '0;
            acc_q   <= '0;
            lfsr_q  <= 32'd1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            amp_q   <= amp_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            x_out_q <= x_out_d;
            acc_q   <= acc_d;
            lfsr_q  <= lfsr_d;
            done_q  <= done_d;
        end
    end

    // Next-state: burst capture, sample advance on transfer, abort and completion.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        amp_d   = amp_q;
        len_d   = len_q;
        idx_d   = idx_q;
        x_out_d = x_out_q;
        acc_d   = acc_q;
        lfsr_d  = lfsr_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        mode_d  = mode_t'(mode);
                        amp_d   = amp;
                        len_d   = len;
                        idx_d   = '0;
                        acc_d   = '0;
                        lfsr_d  = seed_c;
                        unique case (mode_t'(mode))
                            M_IMPULSE: x_out_d = amp;
                            M_STEP:    x_out_d = amp;
                            M_RAMP:    x_out_d = '0;
                            M_NOISE:   x_out_d = W'(seed_c);
                            default:   x_out_d = '0;
                        endcase
                    end
                end
            end
            S_RUN: begin
                // x_valid is high throughout RUN, so x_ready alone marks a transfer.
                if (stop) begin
                    state_d = S_IDLE;
                end else if (xs.x_ready) begin
                    if (idx_q == len_q - CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + CNT_W'(1);
                        acc_d  = acc_q + amp_q;
                        lfsr_d = lfsr_nxt_c;
                        unique case (mode_q)
                            M_IMPULSE: x_out_d = '0;
                            M_STEP:    x_out_d = amp_q;
                            M_RAMP:    x_out_d = acc_q + amp_q;
                            M_NOISE:   x_out_d = W'(lfsr_nxt_c);
                            default:   x_out_d = '0;
                        endcase
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs come straight from flops; valid and busy are the RUN state itself.
    assign xs.x_out   = x_out_q;
    assign xs.x_valid = (state_q == S_RUN);
    assign xs.idx     = idx_q;
    assign busy       = (state_q == S_RUN);
    assign done       = done_q;

endmodule

// File: tb/tb_bqf_stim_gen.sv
// Self-checking bench for bqf_stim_gen: directed scenarios plus randomized bursts vs. a sample model.
module tb_bqf_stim_gen;

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             clr;
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [W-1:0]     amp;
    logic [CNT_W-1:0] len;
    logic             busy;
    logic             done;

    bqf_stim_gen_if #(.W(W), .CNT_W(CNT_W)) xs ();

    bqf_stim_gen #(.W(W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .amp   (amp),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .xs    (xs)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Results of the most recent burst.
    logic [W-1:0]     got_q[$];
    logic [CNT_W-1:0] gidx_q[$];
    int  xfers, valid_cycles, holds_bad, busy_bad, done_early;
    bit  done_seen, busy_end, timed_out;

    // Expected n-th sample of a burst, straight from the sample rules.
    function automatic logic [W-1:0] model_sample(input logic [1:0] m, input logic [W-1:0] a, input int n);
        logic [31:0] q;
        case (m)
            2'd0:    return (n == 0) ? a : '0;
            2'd1:    return a;
            2'd2:    return W'(a * W'(n));
            default: begin
                q = (a == '0) ? 32'd1 : 32'(a);
                for (int k = 0; k < n; k++)
                    q = q[0] ? ((q >> 1) ^ 32'h8020_0003) : (q >> 1);
                return W'(q);
            end
        endcase
    endfunction

    // Issues start now (caller is away from the rising edge) and runs the burst to its end.
    // rmode: 0 ready always high, 1 ready toggles 1,0,1,..., 2 ready random.
    // stop_at: nonzero asserts stop together with that transfer number.
    task automatic drive_burst(input logic [1:0] m, input logic [W-1:0] a, input logic [CNT_W-1:0] l,
                               input int rmode, input int stop_at);
        logic [W-1:0]     prev_x;
        logic [CNT_W-1:0] prev_i;
        bit               prev_stall;
        bit               r;
        got_q.delete();
        gidx_q.delete();
        xfers = 0; valid_cycles = 0; holds_bad = 0; busy_bad = 0; done_early = 0;
        done_seen = 1'b0; busy_end = 1'b1; timed_out = 1'b1;
        prev_stall = 1'b0; prev_x = '0; prev_i = '0;
        start = 1'b1; mode = m; amp = a; len = l;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 2'($urandom);
        amp   = W'($urandom);
        len   = CNT_W'($urandom);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (!xs.x_valid) begin
                done_seen = done;
                busy_end  = busy;
                timed_out = 1'b0;
                break;
            end
            valid_cycles++;
            if (busy !== 1'b1) busy_bad++;
            if (done !== 1'b0) done_early++;
            if (prev_stall && (xs.x_out !== prev_x || xs.idx !== prev_i)) holds_bad++;
            case (rmode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            xs.x_ready = r;
            stop = (stop_at != 0) && r && (xfers + 1 == stop_at);
            if (r) begin
                got_q.push_back(xs.x_out);
                gidx_q.push_back(xs.idx);
                xfers++;
            end
            prev_stall = !r;
            prev_x     = xs.x_out;
            prev_i     = xs.idx;
            @(posedge clk);
            #1;
            stop = 1'b0;
        end
        xs.x_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (xs.x_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", xs.x_valid); else n_pass++;
        n_checks++; if (xs.x_out !== '0) $display("FAIL reset_xout: got %h want 0", xs.x_out); else n_pass++;
        n_checks++; if (xs.idx !== '0) $display("FAIL reset_idx: got %0d want 0", xs.idx); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        @(negedge clk);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (xs.x_valid !== 1'b0) $display("FAIL idle_valid: got %b want 0", xs.x_valid); else n_pass++;
    endtask

    task automatic test_impulse();
        logic [W-1:0] e;
        @(negedge clk);
        drive_burst(2'd0, W'(5), CNT_W'(4), 0, 0);
        n_checks++; if (timed_out) $display("FAIL imp_timeout: burst did not end"); else n_pass++;
        n_checks++; if (xfers != 4) $display("FAIL imp_xfers: got %0d want 4", xfers); else n_pass++;
        n_checks++; if (valid_cycles != 4) $display("FAIL imp_valid_cycles: got %0d want 4", valid_cycles); else n_pass++;
        for (int i = 0; i < got_q.size(); i++) begin
            e = (i == 0) ? W'(5) : '0;
            n_checks++; if (got_q[i] !== e) $display("FAIL imp_sample[%0d]: got %h want %h", i, got_q[i], e); else n_pass++;
            n_checks++; if (gidx_q[i] !== CNT_W'(i)) $display("FAIL imp_idx[%0d]: got %0d want %0d", i, gidx_q[i], i); else n_pass++;
        end
        n_checks++; if (!done_seen) $display("FAIL imp_done: got 0 want 1"); else n_pass++;
        n_checks++; if (busy_end) $display("FAIL imp_busy_end: got 1 want 0"); else n_pass++;
        n_checks++; if (done_early != 0 || busy_bad != 0) $display("FAIL imp_flags: done_early %0d busy_bad %0d want 0 0", done_early, busy_bad); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL imp_done_pulse: got %b want 0", done); else n_pass++;
    endtask

    task automatic test_ramp_backpressure();
        @(negedge clk);
        drive_burst(2'd2, W'(3), CNT_W'(5), 1, 0);
        n_checks++; if (xfers != 5) $display("FAIL ramp_xfers: got %0d want 5", xfers); else n_pass++;
        n_checks++; if (holds_bad != 0) $display("FAIL ramp_hold: got %0d unstable stalls want 0", holds_bad); else n_pass++;
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== W'(3 * i)) $display("FAIL ramp_sample[%0d]: got %0d want %0d", i, got_q[i], 3 * i); else n_pass++;
        end
        n_checks++; if (!done_seen) $display("FAIL ramp_done: got 0 want 1"); else n_pass++;
    endtask

    task automatic test_noise();
        logic [31:0] exp_n [3];
        exp_n[0] = 32'h0000_0001;
        exp_n[1] = 32'h8020_0003;
        exp_n[2] = 32'hC030_0002;
        @(negedge clk);
        for (int pass = 0; pass < 2; pass++) begin
            drive_burst(2'd3, (pass == 0) ? W'(1) : W'(0), CNT_W'(3), 0, 0);
            n_checks++; if (xfers != 3) $display("FAIL noise%0d_xfers: got %0d want 3", pass, xfers); else n_pass++;
            for (int i = 0; i < got_q.size(); i++) begin
                n_checks++; if (got_q[i] !== W'(exp_n[i])) $display("FAIL noise%0d_sample[%0d]: got %h want %h", pass, i, got_q[i], exp_n[i]); else n_pass++;
            end
            n_checks++; if (!done_seen) $display("FAIL noise%0d_done: got 0 want 1", pass); else n_pass++;
        end
    endtask

    task automatic test_len_zero_back_to_back();
        @(negedge clk);
        drive_burst(2'd1, W'(4), CNT_W'(0), 0, 0);
        n_checks++; if (valid_cycles != 0) $display("FAIL len0_valid: got %0d valid cycles want 0", valid_cycles); else n_pass++;
        n_checks++; if (!done_seen) $display("FAIL len0_done: got 0 want 1"); else n_pass++;
        drive_burst(2'd1, W'(7), CNT_W'(2), 0, 0);
        n_checks++; if (xfers != 2) $display("FAIL b2b_xfers: got %0d want 2", xfers); else n_pass++;
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== W'(7)) $display("FAIL b2b_sample[%0d]: got %0d want 7", i, got_q[i]); else n_pass++;
        end
        n_checks++; if (!done_seen) $display("FAIL b2b_done: got 0 want 1"); else n_pass++;
    endtask

    task automatic test_stop();
        @(negedge clk);
        drive_burst(2'd1, W'(9), CNT_W'(10), 0, 3);
        n_checks++; if (xfers != 3) $display("FAIL stop_xfers: got %0d want 3", xfers); else n_pass++;
        n_checks++; if (valid_cycles != 3) $display("FAIL stop_valid_cycles: got %0d want 3", valid_cycles); else n_pass++;
        n_checks++; if (done_seen) $display("FAIL stop_done: got 1 want 0"); else n_pass++;
        n_checks++; if (busy_end) $display("FAIL stop_busy: got 1 want 0"); else n_pass++;
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== W'(9)) $display("FAIL stop_sample[%0d]: got %0d want 9", i, got_q[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        start = 1'b1; mode = 2'd2; amp = W'($urandom) | W'(1); len = CNT_W'(50);
        xs.x_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        n_checks++; if (xs.x_valid !== 1'b1) $display("FAIL rst_mid_pre_valid: got %b want 1", xs.x_valid); else n_pass++;
        clr = 1'b0;
        #1;
        n_checks++; if (xs.x_out !== '0) $display("FAIL rst_mid_xout: got %h want 0", xs.x_out); else n_pass++;
        n_checks++; if (xs.x_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", xs.x_valid); else n_pass++;
        n_checks++; if (xs.idx !== '0) $display("FAIL rst_mid_idx: got %0d want 0", xs.idx); else n_pass++;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_flags: got busy %b done %b want 0 0", busy, done); else n_pass++;
        xs.x_ready = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        drive_burst(2'd2, W'(2), CNT_W'(2), 0, 0);
        n_checks++; if (xfers != 2) $display("FAIL rst_fresh_xfers: got %0d want 2", xfers); else n_pass++;
        for (int i = 0; i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== W'(2 * i)) $display("FAIL rst_fresh_sample[%0d]: got %0d want %0d", i, got_q[i], 2 * i); else n_pass++;
        end
        n_checks++; if (!done_seen) $display("FAIL rst_fresh_done: got 0 want 1"); else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0]       m;
        logic [W-1:0]     a;
        logic [CNT_W-1:0] l;
        logic [W-1:0]     e;
        int               sa;
        int               exp_x;
        @(negedge clk);
        for (int t = 0; t < 30; t++) begin
            m  = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            l  = CNT_W'($urandom_range(1, 24));
            sa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(l)) : 0;
            exp_x = (sa != 0) ? sa : int'(l);
            drive_burst(m, a, l, 2, sa);
            n_checks++; if (timed_out) $display("FAIL rnd%0d_timeout: burst did not end", t); else n_pass++;
            n_checks++; if (xfers != exp_x) $display("FAIL rnd%0d_xfers: got %0d want %0d", t, xfers, exp_x); else n_pass++;
            n_checks++; if (holds_bad != 0) $display("FAIL rnd%0d_hold: got %0d unstable stalls want 0", t, holds_bad); else n_pass++;
            n_checks++; if (done_seen != (sa == 0)) $display("FAIL rnd%0d_done: got %b want %b", t, done_seen, (sa == 0)); else n_pass++;
            for (int i = 0; i < got_q.size(); i++) begin
                e = model_sample(m, a, i);
                n_checks++; if (got_q[i] !== e) $display("FAIL rnd%0d_sample[%0d]: mode %0d got %h want %h", t, i, m, got_q[i], e); else n_pass++;
                n_checks++; if (gidx_q[i] !== CNT_W'(i)) $display("FAIL rnd%0d_idx[%0d]: got %0d want %0d", t, i, gidx_q[i], i); else n_pass++;
            end
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        clr = 1'b0; start = 1'b0; stop = 1'b0;
        mode = '0; amp = '0; len = '0;
        xs.x_ready = 1'b0;
        test_reset();
        test_impulse();
        test_ramp_backpressure();
        test_noise();
        test_len_zero_back_to_back();
        test_stop();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bqf_stim_gen.md
# bqf_stim_gen

Test-stimulus transmitter for the biquad filter datapath. Produces a length-limited stream of input samples (impulse, step, ramp or pseudo-random noise) on a valid/ready interface that feeds the filter's `Xin` input. This replaces hand-written `Xin` sequences in benches and board bring-up. It sits upstream of the filter, in the same clock domain.

## Interface

- W, 32, sample width; the noise generator is 32-bit and its low W bits are output when W < 32
- CNT_W, 16, width of the sample counter and length field
- clk  input  1  clock; all state changes on rising edge
- clr  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE
- stop  input  1  synchronous abort; ignored in IDLE
- mode  input  2  stimulus type (0 impulse, 1 step, 2 ramp, 3 noise); captured at start
- amp  input  W  amplitude, or ramp increment, or noise seed; captured at start
- len  input  CNT_W  number of samples in the burst; captured at start
- x_out  output  W  current sample to the filter
- x_valid  output  1  x_out holds a valid sample
- x_ready  input  1  downstream accepts a sample; a transfer happens on a cycle with x_valid && x_ready
- idx  output  CNT_W  index of the sample currently presented (0-based)
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when a burst completes normally

## Operation

- States: IDLE, RUN.
- IDLE -> RUN: start=1 with len!=0. mode, amp and len are latched. x_out is loaded with sample 0. idx=0, x_valid=1.
- In IDLE, start=1 with len=0 does not enter RUN. done pulses on the next cycle and no samples are sent.
- start is ignored in RUN. mode, amp and len may change freely after capture.
- On each transfer in RUN:
  - If idx == len-1, go to IDLE with x_valid=0 and done=1.
  - Otherwise idx increments and x_out advances to the next sample.
- Sample rules, where n is idx and all arithmetic is modulo 2^W:
  - impulse: amp at n=0, otherwise 0.
  - step: amp for every n.
  - ramp: n*amp, produced by an accumulator that starts at 0 and adds amp on each transfer.
  - noise: sample 0 is the seed, which is amp, or 1 if amp==0. The next value is q_next = (q>>1) ^ (q[0] ? 32'h80200003 : 0).
- Backpressure: while x_valid && !x_ready, x_out, idx and the generator state hold exactly.
- stop in RUN: go to IDLE on the next edge with x_valid=0 and no done pulse. If a transfer occurs in the same cycle, that sample counts as delivered and is not repeated.
- Reset (clr low, at any time, including mid-burst):
  - State goes to IDLE immediately.
  - x_out=0, x_valid=0, idx=0, busy=0, done=0, accumulator=0, noise register=1.
  - A partial burst is discarded.

## Timing

- Start latency is one cycle: start is seen at edge k, and x_valid=1 with sample 0 is presented after edge k.
- Throughput is one sample per cycle while x_ready=1.
- A burst of N samples with x_ready held at 1 occupies N cycles of x_valid.
- done is asserted in the cycle after the final transfer, coincident with x_valid=0 and busy=0.
- A new start is accepted in that same done cycle.
- busy equals x_valid in RUN.
- All outputs are registered, with no combinational path from x_ready to x_out or x_valid.

## Test plan

- Impulse, amp=5, len=4, x_ready=1: x_out 5,0,0,0 on four consecutive valid cycles, idx 0..3, then done pulses once with x_valid=0.
- Ramp, amp=3, len=5, with x_ready toggling 1,0,1,0…: accepted samples are 0,3,6,9,12. x_out and idx are stable during every ready=0 cycle, and exactly 5 transfers occur.
- Noise, amp=1, len=3, x_ready=1: samples 0x00000001, 0x80200003, 0xC0300002. Repeating with amp=0 gives the same sequence.
- len=0 start: no x_valid, done=1 one cycle after start. Then a step burst with amp=7, len=2 starting in that done cycle yields 7,7.
- Step, amp=9, len=10, with stop asserted on the same cycle as the 3rd transfer: exactly 3 samples are delivered, x_valid falls next cycle, no done pulse, busy=0.
- Reset mid-burst: pull clr low asynchronously between edges during a ramp. All outputs read 0 before the next edge. After release, a fresh start with amp=2, len=2 gives 0,2.
